// File: rtl/pe_array_drain_if.sv
// Row-stream bundle between the PE-array drain and its neighbours: snapshot request,
// status flags and the valid/ready row beat.
interface pe_array_drain_if #(
    parameter int ARRAY_DIM   = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5
);
    localparam int ROW_W = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;

    logic                                     start;
    logic [SHIFT_WIDTH-1:0]                   shift_amt;
    logic [ARRAY_DIM*ARRAY_DIM*ACC_WIDTH-1:0] acc_in;
    logic                                     busy;
    logic                                     done;
    logic                                     out_valid;
    logic                                     out_ready;
    logic [ARRAY_DIM*OUT_WIDTH-1:0]           out_data;
    logic [ROW_W-1:0]                         out_row;
    logic                                     out_last;

    // The drain produces the row stream, so it is the master.
    modport master (
        input  start, shift_amt, acc_in, out_ready,
        output busy, done, out_valid, out_data, out_row, out_last
    );

    modport slave (
        output start, shift_amt, acc_in, out_ready,
        input  busy, done, out_valid, out_data, out_row, out_last
    );
endinterface

// File: rtl/pe_array_drain.sv
// Snapshots the PE-array accumulators on start, requantizes to signed OUT_WIDTH and streams
// one row per beat. Define DRAIN_RELU_EN to clamp negative results to zero before saturation.
module pe_array_drain #(
    parameter int ARRAY_DIM   = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    pe_array_drain_if.master   dif
);
    localparam int ROW_W = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARRAY_DIM - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t                        state;
    logic                          capture;
    logic signed [ACC_WIDTH-1:0]   acc_buf_p0 [ARRAY_DIM][ARRAY_DIM];
    logic [SHIFT_WIDTH-1:0]        shift_p0;

    function automatic logic [SHIFT_WIDTH-1:0] clamp_shift(input logic [SHIFT_WIDTH-1:0] s);
        int v;
        v = int'(s);
        if (v > ACC_WIDTH - 1) return SHIFT_WIDTH'(ACC_WIDTH - 1);
        return s;
    endfunction

    // One extra bit of headroom so the rounding bias cannot overflow the maximum accumulator.
    function automatic logic signed [ACC_WIDTH:0] round_shift(
        input logic signed [ACC_WIDTH-1:0] x,
        input logic [SHIFT_WIDTH-1:0]      s
    );
        logic signed [ACC_WIDTH:0] ext;
        logic signed [ACC_WIDTH:0] bias;
        ext  = {x[ACC_WIDTH-1], x};
        bias = '0;
        if (s != '0) bias[s - 1'b1] = 1'b1;
        return (ext + bias) >>> s;
    endfunction

    function automatic logic signed [ACC_WIDTH:0] relu(input logic signed [ACC_WIDTH:0] y);
`ifdef DRAIN_RELU_EN
        return (y < 0) ? '0 : y;
`else
        return y;
`endif
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH:0] y);
        if (y > SAT_MAX) return SAT_MAX[OUT_WIDTH-1:0];
        if (y < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
        return y[OUT_WIDTH-1:0];
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] requant(
        input logic signed [ACC_WIDTH-1:0] x,
        input logic [SHIFT_WIDTH-1:0]      s
    );
        return saturate(relu(round_shift(x, s)));
    endfunction

    assign capture = (state == ST_IDLE) && dif.start;

    // Stage p0: snapshot buffer, free of reset so the array can be reused immediately.
    always_ff @(posedge clk) begin
        if (capture) begin
            shift_p0 <= clamp_shift(dif.shift_amt);
            for (int r = 0; r < ARRAY_DIM; r++) begin
                for (int c = 0; c < ARRAY_DIM; c++) begin
                    acc_buf_p0[r][c] <= dif.acc_in[(r*ARRAY_DIM + c)*ACC_WIDTH +: ACC_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            dif.busy      <= 1'b0;
            dif.done      <= 1'b0;
            dif.out_valid <= 1'b0;
            dif.out_last  <= 1'b0;
            dif.out_row   <= '0;
        end else begin
            dif.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dif.start) begin
                        state         <= ST_SEND;
                        dif.busy      <= 1'b1;
                        dif.out_valid <= 1'b1;
                        dif.out_row   <= '0;
                        dif.out_last  <= (LAST_ROW == '0);
                    end
                end
                ST_SEND: begin
                    if (dif.out_ready) begin
                        if (dif.out_row == LAST_ROW) begin
                            state         <= ST_DONE;
                            dif.busy      <= 1'b0;
                            dif.out_valid <= 1'b0;
                            dif.out_last  <= 1'b0;
                            dif.done      <= 1'b1;
                        end else begin
                            dif.out_row  <= dif.out_row + 1'b1;
                            dif.out_last <= ((dif.out_row + 1'b1) == LAST_ROW);
                        end
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    dif.out_row <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage p1: requantize the presented row straight from the buffer; zero when idle.
    always_comb begin
        dif.out_data = '0;
        if (dif.out_valid) begin
            for (int c = 0; c < ARRAY_DIM; c++) begin
                dif.out_data[c*OUT_WIDTH +: OUT_WIDTH] = requant(acc_buf_p0[dif.out_row][c], shift_p0);
            end
        end
    end
endmodule

// File: tb/tb_pe_array_drain.sv
// Randomized bench for pe_array_drain against an arithmetic requantization model.
module tb_pe_array_drain;
    localparam int DIM = 16;
    localparam int AW  = 32;
    localparam int OW  = 8;
    localparam int SW  = 5;

    logic clk = 1'b0;
    logic rst_n;

    pe_array_drain_if #(.ARRAY_DIM(DIM), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW)) dif ();

    pe_array_drain #(.ARRAY_DIM(DIM), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int acc_m [DIM][DIM];
    logic [DIM*OW-1:0] exp_row [DIM];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Round half up, then floor-divide by 2^s, then clip.
    function automatic int requant_ref(input longint x, input int s);
        longint v, d, q;
        if (s > AW - 1) s = AW - 1;
        if (s == 0) begin
            q = x;
        end else begin
            d = longint'(1) << s;
            v = x + d / 2;
            q = v / d;
            if ((v % d) != 0 && v < 0) q = q - 1;
        end
`ifdef DRAIN_RELU_EN
        if (q < 0) q = 0;
`endif
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    task automatic build_exp(input int sh);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                exp_row[r][c*OW +: OW] = OW'(requant_ref(longint'(acc_m[r][c]), sh));
    endtask

    task automatic drive_acc();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                dif.acc_in[(r*DIM + c)*AW +: AW] = acc_m[r][c];
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                acc_m[r][c] = v;
    endtask

    task automatic fill_rand(input int sh);
        int lim;
        int e;
        e = (sh + 7 > 29) ? 29 : sh + 7;
        lim = 1 << e;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                acc_m[r][c] = ($urandom_range(0, 3) == 0) ? int'($urandom)
                                                          : int'($urandom_range(0, 2*lim)) - lim;
    endtask

    // Called at a negedge; drives start there so the frame begins on the next posedge.
    task automatic run_frame(input int sh, input int stall_row, input int stall_n,
                             input bit disturb, input int abort_row);
        int r, cyc, left;
        bit rdy;
        build_exp(sh);
        drive_acc();
        dif.shift_amt = SW'(sh);
        dif.start     = 1'b1;
        dif.out_ready = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        chk("busy_t1", dif.busy, 1);
        r = 0;
        cyc = 0;
        left = stall_n;
        while (r < DIM && cyc < 64) begin
            if (r == abort_row) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk("rst_busy", dif.busy, 0);
                chk("rst_valid", dif.out_valid, 0);
                chk("rst_row", dif.out_row, 0);
                chk("rst_done", dif.done, 0);
                chk("rst_data", dif.out_data, 0);
                rst_n = 1'b1;
                @(negedge clk);
                chk("rst_nodone", dif.done, 0);
                chk("rst_idle", dif.out_valid, 0);
                return;
            end
            chk("valid", dif.out_valid, 1);
            chk("row", dif.out_row, r);
            chk("last", dif.out_last, r == DIM - 1);
            chk("data", dif.out_data, exp_row[r]);
            rdy = !(r == stall_row && left > 0);
            if (!rdy) left--;
            dif.out_ready = rdy;
            if (disturb && r < DIM - 1) begin
                dif.start = 1'b1;
                for (int i = 0; i < DIM*DIM; i++) dif.acc_in[i*AW +: AW] = $urandom;
                dif.shift_amt = SW'($urandom);
            end else begin
                dif.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (rdy) r++;
        end
        dif.start = 1'b0;
        chk("drained", r, DIM);
        chk("latency", cyc, DIM + stall_n);
        chk("done", dif.done, 1);
        chk("done_busy", dif.busy, 0);
        chk("done_valid", dif.out_valid, 0);
        @(negedge clk);
        chk("done_once", dif.done, 0);
        chk("idle_busy", dif.busy, 0);
        chk("idle_valid", dif.out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sh;
        rst_n         = 1'b0;
        dif.start     = 1'b0;
        dif.out_ready = 1'b0;
        dif.shift_amt = '0;
        dif.acc_in    = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", dif.busy, 0);
        chk("reset_done", dif.done, 0);
        chk("reset_valid", dif.out_valid, 0);
        chk("reset_last", dif.out_last, 0);
        chk("reset_row", dif.out_row, 0);
        chk("reset_data", dif.out_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                acc_m[r][c] = r*DIM + c;
        run_frame(0, -1, 0, 1'b0, -1);

        fill_const(6);
        run_frame(2, -1, 0, 1'b0, -1);
        fill_const(-6);
        run_frame(2, -1, 0, 1'b0, -1);
        fill_const(32'h7FFFFFFF);
        run_frame(4, -1, 0, 1'b0, -1);
        fill_const(32'h80000000);
        run_frame(0, -1, 0, 1'b0, -1);

        fill_rand(8);
        run_frame(8, 5, 3, 1'b0, -1);

        fill_rand(10);
        run_frame(10, -1, 0, 1'b1, -1);

        fill_rand(6);
        run_frame(6, -1, 0, 1'b0, 8);
        fill_rand(3);
        run_frame(3, -1, 0, 1'b0, -1);

        for (int k = 0; k < 12; k++) begin
            sh = int'($urandom_range(0, 31));
            fill_rand(sh);
            run_frame(sh, int'($urandom_range(0, DIM - 1)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/pe_array_drain.md
Name: pe_array_drain

Overview:
- Downstream stage of the 16x16 PE array.
- On `start`, snapshots the array's parallel accumulator bus and the requantization shift.
- Requantizes each 32-bit accumulator to signed 8-bit: round-half-up arithmetic right shift, then saturate.
- Streams the result out one row per beat over a valid/ready handshake, so the array can be cleared and reused while the drain runs.

Parameters:
- ARRAY_DIM, 16, rows/columns of the PE array (rows emitted, lanes per beat).
- ACC_WIDTH, 32, signed accumulator width per PE.
- OUT_WIDTH, 8, signed output element width.
- SHIFT_WIDTH, 5, width of the requantization shift amount.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle request to capture acc_in and begin draining.
- shift_amt  in  SHIFT_WIDTH  right-shift amount, unsigned, sampled with start.
- acc_in  in  ARRAY_DIM*ARRAY_DIM*ACC_WIDTH  accumulators; row-major, PE(r,c) at [(r*ARRAY_DIM+c)*ACC_WIDTH +: ACC_WIDTH].
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last row transfers.
- out_valid  out  1  row beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  ARRAY_DIM*OUT_WIDTH  requantized row; lane c at [c*OUT_WIDTH +: OUT_WIDTH].
- out_row  out  clog2(ARRAY_DIM)  index of the row currently presented.
- out_last  out  1  high with out_valid when out_row == ARRAY_DIM-1.

Behaviour:
- Reset (rst_n low at a clock edge):
  - busy, done, out_valid, out_last = 0; out_row = 0; out_data = 0; state = IDLE.
  - Capture buffer contents are don't-care.
  - Reset mid-drain abandons the frame; no done pulse is issued.
- FSM states and transitions:
  - IDLE: on start=1, register all of acc_in and shift_amt into the capture buffer, row counter = 0, go to SEND.
  - SEND: busy=1, out_valid=1, out_row = row counter.
    - On out_valid & out_ready: if row < ARRAY_DIM-1, row++ and stay; else go to DONE.
  - DONE: done=1, busy=0, out_valid=0 for exactly one cycle, then IDLE.
- Latency:
  - start at cycle T gives out_valid=1 and busy=1 at T+1, carrying row 0.
  - With out_ready held high, row k is accepted at T+1+k, and done pulses at T+1+ARRAY_DIM.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data, out_row and out_last hold stable.
  - out_valid never drops without a transfer, except on reset.
- start is ignored in SEND and DONE; it is accepted again only in IDLE.
  - start may be asserted the cycle after done (back-to-back frames).
- acc_in may change freely after the capture cycle; the drain uses only the buffer.
- Requantization of element x (signed ACC_WIDTH), computed in ACC_WIDTH+1 bits to avoid overflow:
  - s = 0: y = x.
  - s > 0: y = (x + 2^(s-1)) >>> s, arithmetic shift.
  - Saturate y to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], i.e. [-128, 127].
  - shift_amt values >= ACC_WIDTH are clamped to ACC_WIDTH-1.
- out_data may be computed combinationally from the buffer row selected by the row counter, or registered, provided the latency above is met.

Optional Feature:
- Macro: DRAIN_RELU_EN.
- Defined: after shifting and before saturation, negative y is forced to 0, so outputs lie in [0, 127].
- Undefined: signed output range [-128, 127] as specified above.
- Timing and handshake are identical in both builds.

Test Plan:
- Basic drain: acc PE(r,c) = r*16+c, shift=0, out_ready=1, start at T → rows 0..15 at T+1..T+16; lane c of row r = r*16+c, saturated to 127 where the value exceeds 127; out_last only on row 15; done at T+17.
- Rounding: all acc = 6, shift=2 → every lane = 2 (6+2=8, >>2). All acc = -6, shift=2 → every lane = -1 (-6+2=-4, >>2).
- Saturation: acc = 0x7FFFFFFF with shift=4 → 127. acc = 0x80000000 with shift=0 → -128. With DRAIN_RELU_EN, the -128 case → 0.
- Backpressure: out_ready low for 3 cycles on row 5 → out_data and out_row=5 stable across those cycles; no row skipped or repeated; done delayed by exactly 3 cycles.
- Start while busy and acc_in change: pulse start and alter acc_in during SEND → no restart; emitted data matches the originally captured snapshot.
- Reset mid-drain: rst_n low after row 7 transfers → next cycle busy=0, out_valid=0, out_row=0, no done. A fresh start then drains all 16 rows normally.
